// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel type, XGA timing defaults, FSM states and a window-decode helper
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } vtg_state_t;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  // Half-open interval test [lo, hi) used for active and sync windows
  function automatic logic in_window(input logic [31:0] val, input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/video_fifo.sv
// rtl/video_fifo.sv - synchronous first-word-fall-through FIFO with registered full/empty and level
module video_fifo #(
  parameter int  WIDTH = 24,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Pointer and occupancy update; full/empty are decoded from the next level so they come out of flops
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - FIFO-buffered raster generator (DE/HSync/VSync/RGB); VTG_UNDERFLOW_CNT_EN adds UnderflowCount
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE   = XGA_H_ACTIVE,
  parameter int   H_FP       = XGA_H_FP,
  parameter int   H_SYNC     = XGA_H_SYNC,
  parameter int   H_BP       = XGA_H_BP,
  parameter int   V_ACTIVE   = XGA_V_ACTIVE,
  parameter int   V_FP       = XGA_V_FP,
  parameter int   V_SYNC     = XGA_V_SYNC,
  parameter int   V_BP       = XGA_V_BP,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   FIFO_DEPTH = 16,
  parameter int   FILL_LEVEL = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [23:0] Video,
  input  logic        VideoValid,
  output logic        VideoReady,
  output logic        DviDe,
  output logic        DviHSync,
  output logic        DviVSync,
  output logic [23:0] DviRgb,
`ifdef VTG_UNDERFLOW_CNT_EN
  output logic [15:0] UnderflowCount,
`endif
  output logic        Underflow
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int HW       = $clog2(H_TOTAL + 1);
  localparam int VW       = $clog2(V_TOTAL + 1);
  localparam int LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [LW-1:0] FILL_L = LW'(FILL_LEVEL);

  vtg_state_t    state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          uf_q, uf_d;
  pixel_t        rgb_q, rgb_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  pixel_t        fifo_head;
  logic          running, active, starved, hs_win, vs_win;

  // Ready depends only on flops (state and registered full), never on VideoValid
  assign VideoReady = (state_q != IDLE) && !fifo_full;
  assign fifo_push  = VideoValid && VideoReady;

  video_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset),
    .push  (fifo_push),
    .wdata (Video),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign running = (state_q == RUN);
  assign active  = running
                && in_window(32'(h_cnt_q), 32'(0), 32'(H_ACTIVE))
                && in_window(32'(v_cnt_q), 32'(0), 32'(V_ACTIVE));
  assign hs_win  = in_window(32'(h_cnt_q), 32'(HS_START), 32'(HS_START + H_SYNC));
  assign vs_win  = in_window(32'(v_cnt_q), 32'(VS_START), 32'(VS_START + V_SYNC));
  assign fifo_pop = active && !fifo_empty;
  assign starved  = active && fifo_empty;

  // Start-up sequencing: one idle cycle, then wait for the prefill, then run until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = WAIT;
      WAIT:    if (fifo_level >= FILL_L) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Raster counters advance only while running; otherwise pinned at pixel (0,0)
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (running) begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
    end
  end

  // Output decode from the current counter value and FIFO head; registered one cycle later
  always_comb begin
    de_d  = active;
    rgb_d = fifo_pop ? fifo_head : '0;
    hs_d  = (running && hs_win) ? HS_POL : ~HS_POL;
    vs_d  = (running && vs_win) ? VS_POL : ~VS_POL;
    uf_d  = uf_q | starved;
  end

  // State, counters and output registers, all cleared asynchronously
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      uf_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      uf_q    <= uf_d;
      rgb_q   <= rgb_d;
    end
  end

  assign DviDe     = de_q;
  assign DviHSync  = hs_q;
  assign DviVSync  = vs_q;
  assign DviRgb    = rgb_q;
  assign Underflow = uf_q;

`ifdef VTG_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of active slots that found the FIFO empty
  always_comb begin
    ucnt_d = ucnt_q;
    if (starved && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  // Underflow counter register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign UnderflowCount = ucnt_q;
`endif

endmodule
